cnn_concat_nin: RTL and testbench
=================================

CNN_CONCAT_NIN -- requirements
Module: cnn_concat_nin

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter NUM_IN, default 2, number of input streams; legal range 2..8.
REQ-003 SHALL have parameter SEG_LEN, default 16, elements taken from each input per output frame; must be at least 1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, per-input buffer depth; must be a power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port valid_in, input, NUM_IN bits: bit k qualifies element k.
REQ-008 SHALL have port in_data, input, NUM_IN*DATA_WIDTH bits: element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port out, output, DATA_WIDTH bits: concatenated stream data, registered.
REQ-010 SHALL have port valid_out, output, 1 bit: qualifies out, registered.
REQ-011 SHALL have port frame_end, output, 1 bit: high together with the last element of each output frame.

Function
REQ-012 SHALL write each input k into its own FIFO on every cycle where valid_in[k]=1; there is no backpressure.
REQ-013 SHALL emit frames as SEG_LEN elements of input 0, then SEG_LEN of input 1, up to input NUM_IN-1, then repeat from input 0.
REQ-014 SHALL use a selector sel (0..NUM_IN-1) and a segment counter cnt (0..SEG_LEN-1).
- Pop the FIFO of sel only when that FIFO is non-empty.
- Each pop increments cnt.
- When cnt=SEG_LEN-1 on a pop: cnt returns to 0, sel advances, and sel wraps from NUM_IN-1 to 0.
REQ-015 SHALL hold valid_out=0 and out unchanged on any cycle where FIFO[sel] is empty; it shall never skip to another input.
REQ-016 SHALL have 2-cycle latency from input to output: an element sampled at edge t into an empty selected FIFO appears with valid_out=1 after edge t+1.
REQ-017 SHALL sustain one output per cycle while the selected FIFO is non-empty.
REQ-018 SHALL assert frame_end=1 on the pop where sel=NUM_IN-1 and cnt=SEG_LEN-1; frame_end is 0 otherwise.
REQ-019 SHALL, when FIFO[k] is full and is popped and written in the same cycle, accept the write with no loss.
REQ-020 SHALL, when FIFO[k] is full and is written but not popped, drop the element and leave the FIFO unchanged.
REQ-021 SHALL, when FIFO[k] is empty and is written while sel=k, not bypass: the element is first popped on the next cycle.
REQ-022 SHALL, when SEG_LEN=1, advance sel on every pop.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, clear:
- all FIFO pointers and fill counts;
- sel=0 and cnt=0;
- out=0, valid_out=0 and frame_end=0.
REQ-024 SHALL, when reset is asserted mid-frame, discard all buffered elements; the first element after release starts a new frame at input 0.
REQ-025 SHALL ignore valid_in on any cycle where reset=1.

Configuration
REQ-026 SHALL, with CNN_CONCAT_OVF_STATUS_EN defined, add output port ovf (NUM_IN bits, reset 0).
- Bit k is set on the cycle after a drop on input k (REQ-020).
- Bit k stays set until reset.
REQ-027 SHALL, without CNN_CONCAT_OVF_STATUS_EN defined, have no ovf port and no overflow logic; drops still occur silently.

Structure
REQ-028 SHALL keep the following in shared package cnn_concat_pkg:
- the pointer-width function clog2;
- the default DATA_WIDTH constant;
- the legal-range limit constant for NUM_IN.
REQ-029 SHALL instantiate sub-module cnn_concat_fifo (a synchronous FIFO with full, empty and count outputs) once per input through a generate loop.
REQ-030 SHALL keep the selector/counter FSM and the output register in the top module.

Verification
REQ-031 SHALL cover the basic frame with NUM_IN=2, SEG_LEN=4.
- Stimulus: in0 = 1..4 and in1 = 11..14, all valid on the same cycles.
- Required: out = 1,2,3,4,11,12,13,14 on consecutive cycles; first valid_out 2 cycles after the first valid_in; frame_end only with 14.
REQ-032 SHALL cover selected-input starvation.
- Stimulus: in1 data arrives first, then in0 data 10 cycles later.
- Required: valid_out stays 0 until in0 data arrives; then output is all of in0's segment, then in1's.
REQ-033 SHALL cover overflow with FIFO_DEPTH=4.
- Stimulus: push 6 elements into in1 while sel=0 and FIFO0 is empty.
- Required: the last 2 elements are dropped; ovf[1]=1 when the macro is defined; later output of in1 is its first 4 values only.
REQ-034 SHALL cover full FIFO with simultaneous push and pop.
- Stimulus: FIFO0 full at 4 entries, sel=0, push and pop in the same cycle.
- Required: count stays 4, nothing dropped, ovf[0]=0.
REQ-035 SHALL cover reset mid-frame with NUM_IN=3, SEG_LEN=2.
- Stimulus: assert reset after 3 outputs.
- Required: valid_out=0 the next cycle; the next frame starts with fresh in0 data.
REQ-036 SHALL cover SEG_LEN=1 with NUM_IN=4.
- Stimulus: continuous valid data on all inputs, value 100*k+n for input k, element n.
- Required: out = 1,101,201,301,2,102,...; frame_end on every 4th output.

Source files
------------

// File: rtl/cnn_concat_pkg.sv
// Shared constants and helpers for the multi-input segment concatenator.
package cnn_concat_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int NUM_IN_MIN         = 2;
  localparam int NUM_IN_MAX         = 8;

  // Ceiling log2 with a floor of 1 so single-value ranges still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_concat_fifo.sv
// Synchronous FIFO with show-ahead read data; a write while full is only
// accepted when a pop frees the slot in the same cycle.
module cnn_concat_fifo
  import cnn_concat_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cnn_concat_nin.sv
// Round-robin segment concatenator: SEG_LEN elements from each input in turn.
// Optional sticky per-input overflow flags: define CNN_CONCAT_OVF_STATUS_EN.
//
// state        | meaning
// sel_q        | input whose FIFO is currently being drained
// cnt_q        | elements already taken from sel_q in this segment
module cnn_concat_nin
  import cnn_concat_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_IN     = 2,
  parameter int SEG_LEN    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            valid_in,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0]        out,
  output logic                         valid_out,
  output logic                         frame_end
`ifdef CNN_CONCAT_OVF_STATUS_EN
  ,
  output logic [NUM_IN-1:0]            ovf
`endif
);

  localparam int SEL_W = clog2(NUM_IN);
  localparam int CNT_W = clog2(SEG_LEN);
  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEG_LEN - 1);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("cnn_concat_nin: NUM_IN out of range");
  end
  if (SEG_LEN < 1) begin : g_bad_seg_len
    $error("cnn_concat_nin: SEG_LEN must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cnn_concat_nin: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pop;
  logic                  last_pop;
  logic [NUM_IN-1:0]     wr_en;
  logic [NUM_IN-1:0]     rd_en;
  logic [NUM_IN-1:0]     empty;
  logic [DATA_WIDTH-1:0] rd_data [NUM_IN];
`ifdef CNN_CONCAT_OVF_STATUS_EN
  logic [NUM_IN-1:0]     drop;
`endif

  // Writes are masked during reset so nothing sneaks into a clearing FIFO.
  assign wr_en = reset ? '0 : valid_in;
  assign pop   = !empty[sel_q];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    logic           fifo_full;
    logic [PTR_W:0] fifo_count;
    logic           unused_status;

    assign rd_en[k] = pop && (sel_q == SEL_W'(k));

    cnn_concat_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[k]),
      .wr_data (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en   (rd_en[k]),
      .rd_data (rd_data[k]),
      .full    (fifo_full),
      .empty   (empty[k]),
      .count   (fifo_count)
    );

    assign unused_status = ^{fifo_count, fifo_full};
`ifdef CNN_CONCAT_OVF_STATUS_EN
    assign drop[k] = wr_en[k] && fifo_full && !rd_en[k];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    last_pop = 1'b0;
    if (pop) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        sel_d    = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
        last_pop = (sel_q == SEL_LAST);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      valid_out <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      valid_out <= pop;
      frame_end <= last_pop;
      if (pop) out <= rd_data[sel_q];
    end
  end

`ifdef CNN_CONCAT_OVF_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) ovf <= '0;
    else       ovf <= ovf | drop;
  end
`endif

endmodule

// File: tb/tb_cnn_concat_nin.sv
// Scoreboard bench for cnn_concat_nin across three parameter sets.
module tb_cnn_concat_nin;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // A: NUM_IN=2, SEG_LEN=4, depth 4
  logic [1:0]  a_valid;
  logic [31:0] a_data;
  logic [15:0] a_out;
  logic        a_vo, a_fe;
  // B: NUM_IN=3, SEG_LEN=2, depth 4
  logic [2:0]  b_valid;
  logic [47:0] b_data;
  logic [15:0] b_out;
  logic        b_vo, b_fe;
  // C: NUM_IN=4, SEG_LEN=1, depth 8
  logic [3:0]  c_valid;
  logic [63:0] c_data;
  logic [15:0] c_out;
  logic        c_vo, c_fe;
`ifdef CNN_CONCAT_OVF_STATUS_EN
  logic [1:0]  a_ovf;
  logic [2:0]  b_ovf;
  logic [3:0]  c_ovf;
`endif

  cnn_concat_nin #(.DATA_WIDTH(16), .NUM_IN(2), .SEG_LEN(4), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .valid_in(a_valid), .in_data(a_data),
    .out(a_out), .valid_out(a_vo), .frame_end(a_fe)
`ifdef CNN_CONCAT_OVF_STATUS_EN
    , .ovf(a_ovf)
`endif
  );

  cnn_concat_nin #(.DATA_WIDTH(16), .NUM_IN(3), .SEG_LEN(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .valid_in(b_valid), .in_data(b_data),
    .out(b_out), .valid_out(b_vo), .frame_end(b_fe)
`ifdef CNN_CONCAT_OVF_STATUS_EN
    , .ovf(b_ovf)
`endif
  );

  cnn_concat_nin #(.DATA_WIDTH(16), .NUM_IN(4), .SEG_LEN(1), .FIFO_DEPTH(8)) u_c (
    .clk(clk), .reset(reset), .valid_in(c_valid), .in_data(c_data),
    .out(c_out), .valid_out(c_vo), .frame_end(c_fe)
`ifdef CNN_CONCAT_OVF_STATUS_EN
    , .ovf(c_ovf)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] q_a[$];
  logic [16:0] q_b[$];
  logic [16:0] q_c[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1);
    @(negedge clk);
    a_valid = v;
    a_data  = {d1, d0};
  endtask

  task automatic drive_b(input logic [2:0] v, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2);
    @(negedge clk);
    b_valid = v;
    b_data  = {d2, d1, d0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    a_valid = '0;
    b_valid = '0;
    c_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    a_valid = '0;
    b_valid = '0;
    c_valid = '0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q_a.size() + q_b.size() + q_c.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Each output is compared against the oldest pending expectation.
  always @(negedge clk) begin
    if (a_vo) begin
      if (q_a.size() == 0) chk("a_extra_out", {16'd0, a_out}, 32'hFFFF_FFFF);
      else begin
        logic [16:0] e;
        e = q_a.pop_front();
        chk("a_data", {16'd0, a_out}, {16'd0, e[15:0]});
        chk("a_frame_end", {31'd0, a_fe}, {31'd0, e[16]});
      end
    end else if (a_fe) chk("a_fe_idle", {31'd0, a_fe}, 0);
  end

  always @(negedge clk) begin
    if (b_vo) begin
      if (q_b.size() == 0) chk("b_extra_out", {16'd0, b_out}, 32'hFFFF_FFFF);
      else begin
        logic [16:0] e;
        e = q_b.pop_front();
        chk("b_data", {16'd0, b_out}, {16'd0, e[15:0]});
        chk("b_frame_end", {31'd0, b_fe}, {31'd0, e[16]});
      end
    end else if (b_fe) chk("b_fe_idle", {31'd0, b_fe}, 0);
  end

  always @(negedge clk) begin
    if (c_vo) begin
      if (q_c.size() == 0) chk("c_extra_out", {16'd0, c_out}, 32'hFFFF_FFFF);
      else begin
        logic [16:0] e;
        e = q_c.pop_front();
        chk("c_data", {16'd0, c_out}, {16'd0, e[15:0]});
        chk("c_frame_end", {31'd0, c_fe}, {31'd0, e[16]});
      end
    end else if (c_fe) chk("c_fe_idle", {31'd0, c_fe}, 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    a_valid = '0; a_data = '0;
    b_valid = '0; b_data = '0;
    c_valid = '0; c_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", {31'd0, a_vo}, 0);
    chk("rst_out", {16'd0, a_out}, 0);
    chk("rst_frame_end", {31'd0, a_fe}, 0);
`ifdef CNN_CONCAT_OVF_STATUS_EN
    chk("rst_ovf", {30'd0, a_ovf}, 0);
`endif
    reset = 1'b0;

    // Basic frame: 1..4 then 11..14, two-cycle latency, back-to-back output
    for (int i = 1; i <= 4; i++) q_a.push_back({1'b0, 16'(i)});
    for (int i = 11; i <= 14; i++) q_a.push_back({(i == 14), 16'(i)});
    drive_a(2'b11, 16'd1, 16'd11);
    drive_a(2'b11, 16'd2, 16'd12);
    chk("lat_idle", {31'd0, a_vo}, 0);
    drive_a(2'b11, 16'd3, 16'd13);
    chk("lat_first", {31'd0, a_vo}, 1);
    drive_a(2'b11, 16'd4, 16'd14);
    chk("stream", {31'd0, a_vo}, 1);
    for (int i = 0; i < 6; i++) begin
      drive_a(2'b00, 16'd0, 16'd0);
      chk("stream", {31'd0, a_vo}, 1);
    end
    drive_a(2'b00, 16'd0, 16'd0);
    chk("stream_end", {31'd0, a_vo}, 0);
    drain("drain_basic");

    // Starvation: input 1 first, input 0 ten cycles later
    do_reset();
    for (int i = 30; i <= 33; i++) q_a.push_back({1'b0, 16'(i)});
    for (int i = 20; i <= 23; i++) q_a.push_back({(i == 23), 16'(i)});
    for (int i = 0; i < 10; i++) begin
      if (i < 4) drive_a(2'b10, 16'd0, 16'(20 + i));
      else       drive_a(2'b00, 16'd0, 16'd0);
      chk("starve", {31'd0, a_vo}, 0);
    end
    for (int i = 0; i < 4; i++) drive_a(2'b01, 16'(30 + i), 16'd0);
    drain("drain_starve");

    // Overflow: six pushes into a depth-4 FIFO that is not being drained
    do_reset();
    for (int i = 50; i <= 53; i++) q_a.push_back({1'b0, 16'(i)});
    for (int i = 40; i <= 43; i++) q_a.push_back({(i == 43), 16'(i)});
    for (int i = 0; i < 6; i++) drive_a(2'b10, 16'd0, 16'(40 + i));
    drive_a(2'b00, 16'd0, 16'd0);
`ifdef CNN_CONCAT_OVF_STATUS_EN
    chk("ovf_set", {30'd0, a_ovf}, 2);
`endif
    for (int i = 0; i < 4; i++) drive_a(2'b01, 16'(50 + i), 16'd0);
    drain("drain_ovf");
`ifdef CNN_CONCAT_OVF_STATUS_EN
    chk("ovf_sticky", {30'd0, a_ovf}, 2);
`endif

    // Full FIFO0 with push and pop on the same cycle
    do_reset();
    for (int i = 60; i <= 63; i++) q_a.push_back({1'b0, 16'(i)});
    for (int i = 80; i <= 83; i++) q_a.push_back({(i == 83), 16'(i)});
    for (int i = 70; i <= 73; i++) q_a.push_back({1'b0, 16'(i)});
    for (int i = 90; i <= 93; i++) q_a.push_back({(i == 93), 16'(i)});
    for (int i = 74; i <= 77; i++) q_a.push_back({1'b0, 16'(i)});
    for (int i = 0; i < 4; i++) drive_a(2'b01, 16'(60 + i), 16'd0);
    drive_a(2'b00, 16'd0, 16'd0);
    drive_a(2'b00, 16'd0, 16'd0);
    for (int i = 0; i < 4; i++) drive_a(2'b01, 16'(70 + i), 16'd0);
    for (int i = 0; i < 4; i++) drive_a(2'b10, 16'd0, 16'(80 + i));
    drive_a(2'b00, 16'd0, 16'd0);
    for (int i = 0; i < 4; i++) drive_a(2'b01, 16'(74 + i), 16'd0);
    for (int i = 0; i < 4; i++) drive_a(2'b10, 16'd0, 16'(90 + i));
    drain("drain_full_rw");
`ifdef CNN_CONCAT_OVF_STATUS_EN
    chk("ovf_full_rw", {30'd0, a_ovf}, 0);
`endif

    // Reset mid-frame on the 3-input, SEG_LEN=2 instance
    do_reset();
    q_b.push_back({1'b0, 16'd1});
    q_b.push_back({1'b0, 16'd2});
    q_b.push_back({1'b0, 16'd11});
    drive_b(3'b111, 16'd1, 16'd11, 16'd21);
    drive_b(3'b111, 16'd2, 16'd12, 16'd22);
    drive_b(3'b000, 16'd0, 16'd0, 16'd0);
    drive_b(3'b000, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    reset   = 1'b1;
    b_valid = 3'b111;
    b_data  = {16'd99, 16'd99, 16'd99};
    @(negedge clk);
    chk("midrst_valid_out", {31'd0, b_vo}, 0);
    chk("midrst_out", {16'd0, b_out}, 0);
    q_b.push_back({1'b0, 16'd5});
    q_b.push_back({1'b0, 16'd6});
    q_b.push_back({1'b0, 16'd15});
    q_b.push_back({1'b0, 16'd16});
    q_b.push_back({1'b0, 16'd25});
    q_b.push_back({1'b1, 16'd26});
    reset   = 1'b0;
    b_valid = 3'b111;
    b_data  = {16'd25, 16'd15, 16'd5};
    drive_b(3'b111, 16'd6, 16'd16, 16'd26);
    drain("drain_midrst");

    // SEG_LEN=1 with four inputs: value 100*k+n
    do_reset();
    for (int n = 1; n <= 5; n++)
      for (int k = 0; k < 4; k++) q_c.push_back({(k == 3), 16'(100 * k + n)});
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      c_valid = 4'hF;
      c_data  = {16'(300 + n), 16'(200 + n), 16'(100 + n), 16'(n)};
    end
    drain("drain_seg1");

    chk("queues_empty", q_a.size() + q_b.size() + q_c.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
